// File: rtl/prog_loader.sv
// Streaming program loader: header, instruction words packed into fetch lines, data words.
// Define PROG_LOADER_CKSUM_EN to require a trailing mod-2^32 checksum word after the payload.
module prog_loader #(
    parameter int LANES    = 4,
    parameter int IMEM_AW  = 9,
    parameter int DMEM_AW  = 12,
    parameter int ADDR_LEN = 32
) (
    input  logic                  clk,
    input  logic                  reset_x,
    input  logic                  in_valid,
    output logic                  in_ready,
    input  logic [31:0]           in_data,
    output logic                  imem_we,
    output logic [IMEM_AW-1:0]    imem_addr,
    output logic [LANES*32-1:0]   imem_wdata,
    output logic                  dmem_we,
    output logic [ADDR_LEN-1:0]   dmem_addr,
    output logic [31:0]           dmem_wdata,
    output logic                  loading,
    output logic                  err,
    output logic [2:0]            state_dbg
);

    // Handshake: a word transfers on a rising edge where in_valid & in_ready are both high;
    // in_ready is registered and never depends on in_valid, in_valid may drop at any time.

    localparam int LW   = (LANES > 1) ? $clog2(LANES) : 1;
    localparam int IC_W = IMEM_AW + $clog2(LANES) + 1;
    localparam int DC_W = DMEM_AW + 1;
    localparam logic [32:0] CAP_I = 33'(LANES) << IMEM_AW;
    localparam logic [32:0] CAP_D = 33'(1) << DMEM_AW;
    localparam logic [31:0] NOP   = 32'h0000_0013;

    typedef enum logic [2:0] {
        HDR_I, HDR_D, INSN, DATA, CKSUM, FLUSH, DONE, ERR
    } state_t;

`ifdef PROG_LOADER_CKSUM_EN
    localparam state_t FINAL       = CKSUM;
    localparam logic   FINAL_READY = 1'b1;
    logic [31:0] sum;
`else
    localparam state_t FINAL       = FLUSH;
    localparam logic   FINAL_READY = 1'b0;
`endif

    state_t               state;
    logic [LW-1:0]        lane;
    logic [LANES*32-1:0]  line_buf;
    logic [LANES*32-1:0]  line_next;
    logic [IC_W-1:0]      n_i;
    logic [IC_W-1:0]      i_cnt;
    logic [DC_W-1:0]      n_d;
    logic [DC_W-1:0]      d_cnt;
    logic [IMEM_AW-1:0]   line_idx;
    logic                 take;
    logic                 last_insn;
    logic                 last_data;

    assign take      = in_valid & in_ready;
    assign last_insn = (i_cnt + 1'b1 == n_i);
    assign last_data = (d_cnt + 1'b1 == n_d);
    assign state_dbg = state;

    // Unused lanes of line_buf always hold NOP, so a short final line comes out padded.
    always_comb begin
        line_next = line_buf;
        line_next[(LANES - 1 - int'(lane)) * 32 +: 32] = in_data;
    end

    always_ff @(posedge clk or negedge reset_x) begin
        if (!reset_x) begin
            state      <= HDR_I;
            in_ready   <= 1'b0;
            imem_we    <= 1'b0;
            imem_addr  <= '0;
            imem_wdata <= '0;
            dmem_we    <= 1'b0;
            dmem_addr  <= '0;
            dmem_wdata <= '0;
            loading    <= 1'b1;
            err        <= 1'b0;
            lane       <= '0;
            line_buf   <= {LANES{NOP}};
            n_i        <= '0;
            i_cnt      <= '0;
            n_d        <= '0;
            d_cnt      <= '0;
            line_idx   <= '0;
`ifdef PROG_LOADER_CKSUM_EN
            sum        <= '0;
`endif
        end else begin
            imem_we <= 1'b0;
            dmem_we <= 1'b0;
            case (state)
                HDR_I: begin
                    in_ready <= 1'b1;
                    if (take) begin
                        if ({1'b0, in_data} > CAP_I) begin
                            state    <= ERR;
                            in_ready <= 1'b0;
                            err      <= 1'b1;
                        end else begin
                            n_i   <= in_data[IC_W-1:0];
                            state <= HDR_D;
                        end
                    end
                end
                HDR_D: begin
                    if (take) begin
                        if ({1'b0, in_data} > CAP_D) begin
                            state    <= ERR;
                            in_ready <= 1'b0;
                            err      <= 1'b1;
                        end else begin
                            n_d <= in_data[DC_W-1:0];
                            if (n_i != '0) begin
                                state <= INSN;
                            end else if (in_data != 32'd0) begin
                                state <= DATA;
                            end else begin
                                state    <= FINAL;
                                in_ready <= FINAL_READY;
                            end
                        end
                    end
                end
                INSN: begin
                    if (take) begin
                        i_cnt <= i_cnt + 1'b1;
`ifdef PROG_LOADER_CKSUM_EN
                        sum   <= sum + in_data;
`endif
                        if (lane == LW'(LANES - 1) || last_insn) begin
                            imem_we    <= 1'b1;
                            imem_addr  <= line_idx;
                            imem_wdata <= line_next;
                            line_idx   <= line_idx + 1'b1;
                            line_buf   <= {LANES{NOP}};
                            lane       <= '0;
                        end else begin
                            line_buf <= line_next;
                            lane     <= lane + 1'b1;
                        end
                        if (last_insn) begin
                            if (n_d != '0) begin
                                state <= DATA;
                            end else begin
                                state    <= FINAL;
                                in_ready <= FINAL_READY;
                            end
                        end
                    end
                end
                DATA: begin
                    if (take) begin
                        dmem_we    <= 1'b1;
                        dmem_addr  <= ADDR_LEN'({d_cnt[DMEM_AW-1:0], 2'b00});
                        dmem_wdata <= in_data;
                        d_cnt      <= d_cnt + 1'b1;
`ifdef PROG_LOADER_CKSUM_EN
                        sum        <= sum + in_data;
`endif
                        if (last_data) begin
                            state    <= FINAL;
                            in_ready <= FINAL_READY;
                        end
                    end
                end
`ifdef PROG_LOADER_CKSUM_EN
                CKSUM: begin
                    if (take) begin
                        in_ready <= 1'b0;
                        if (in_data == sum) begin
                            state <= FLUSH;
                        end else begin
                            state <= ERR;
                            err   <= 1'b1;
                        end
                    end
                end
`endif
                // One extra cycle lets the final write land before the core leaves reset.
                FLUSH: begin
                    in_ready <= 1'b0;
                    state    <= DONE;
                end
                DONE: begin
                    in_ready <= 1'b0;
                    loading  <= 1'b0;
                end
                ERR: begin
                    in_ready <= 1'b0;
                    err      <= 1'b1;
                end
                default: begin
                    state    <= ERR;
                    in_ready <= 1'b0;
                    err      <= 1'b1;
                end
            endcase
        end
    end

endmodule
